// File: rtl/puf_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : puf_sequencer                                                 |
// | Purpose  : Two-phase scan-chain sequencer for one PUF instance: shifts a |
// |            challenge pair in, triggers evaluation, and shifts the        |
// |            up/down responses out into parallel registers.                |
// | Options  : PUF_COMPL_CHECK_EN enables the complement check on resp_err.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module puf_sequencer #(
   parameter int CHAL_BITS     = 128,
   parameter int PH_DIV        = 2,
   parameter int TRIG_CYCLES   = 4,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CHAL_BITS-1:0] challenge_a,
   input  logic [CHAL_BITS-1:0] challenge_b,
   output logic                 busy,
   output logic                 done,
   output logic [CHAL_BITS-1:0] response_up,
   output logic [CHAL_BITS-1:0] response_down,
   output logic                 resp_err,
   output logic                 ph1,
   output logic                 ph2,
   output logic                 ca_si,
   output logic                 cb_si,
   output logic                 ph_en,
   output logic                 out_en,
   output logic                 trig,
   input  logic                 so_up,
   input  logic                 so_not_up,
   input  logic                 so_down,
   input  logic                 so_not_down
);

   localparam int SLOT_CYCLES = 4 * PH_DIV;
   localparam int BIT_W       = $clog2(CHAL_BITS);
   localparam int SUB_W       = $clog2(SLOT_CYCLES);
   localparam int WAIT_MAX    = (TRIG_CYCLES > SETTLE_CYCLES) ? TRIG_CYCLES : SETTLE_CYCLES;
   localparam int WAIT_W      = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

   localparam logic [BIT_W-1:0]  c_bit_last    = BIT_W'(CHAL_BITS - 1);
   localparam logic [SUB_W-1:0]  c_sub_last    = SUB_W'(SLOT_CYCLES - 1);
   localparam logic [SUB_W-1:0]  c_sample_sub  = SUB_W'(PH_DIV - 1);
   localparam logic [SUB_W-1:0]  c_s1_lo       = SUB_W'(PH_DIV);
   localparam logic [SUB_W-1:0]  c_s2_lo       = SUB_W'(2 * PH_DIV);
   localparam logic [SUB_W-1:0]  c_s3_lo       = SUB_W'(3 * PH_DIV);
   localparam logic [WAIT_W-1:0] c_trig_last   = WAIT_W'(TRIG_CYCLES - 1);
   localparam logic [WAIT_W-1:0] c_settle_last = WAIT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SHIFT_IN  = 3'd1,
      S_TRIGGER   = 3'd2,
      S_SETTLE    = 3'd3,
      S_SHIFT_OUT = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   state_t               r_state;
   state_t               w_nxt_state;
   logic [SUB_W-1:0]     r_sub;
   logic [SUB_W-1:0]     w_nxt_sub;
   logic [BIT_W-1:0]     r_bit;
   logic [BIT_W-1:0]     w_nxt_bit;
   logic [WAIT_W-1:0]    r_wait;
   logic [WAIT_W-1:0]    w_nxt_wait;
   logic [CHAL_BITS-1:0] r_chal_a;
   logic [CHAL_BITS-1:0] r_chal_b;
   logic [CHAL_BITS-1:0] w_nxt_chal_a;
   logic [CHAL_BITS-1:0] w_nxt_chal_b;
   logic                 w_accept;
   logic                 w_slot_end;
   logic                 w_last_bit;
   logic                 w_sample;
   logic                 w_shifting;
   logic                 w_nxt_ph1;
   logic                 w_nxt_ph2;
   logic                 w_nxt_ca;
   logic                 w_nxt_cb;
   logic                 w_nxt_busy;

   assign w_slot_end = (r_sub == c_sub_last);
   assign w_last_bit = (r_bit == c_bit_last);
   // Last clk of S0 in a response slot: the chain has not yet been advanced by PH1
   assign w_sample   = (r_state == S_SHIFT_OUT) && (r_sub == c_sample_sub);

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_sub   = r_sub;
      w_nxt_bit   = r_bit;
      w_nxt_wait  = r_wait;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_nxt_state = S_SHIFT_IN;
               w_nxt_sub   = '0;
               w_nxt_bit   = '0;
            end
         end
         S_SHIFT_IN, S_SHIFT_OUT: begin
            if (w_slot_end) begin
               w_nxt_sub = '0;
               if (w_last_bit) begin
                  w_nxt_bit   = '0;
                  w_nxt_wait  = '0;
                  w_nxt_state = (r_state == S_SHIFT_IN) ? S_TRIGGER : S_DONE;
               end else begin
                  w_nxt_bit = r_bit + 1'b1;
               end
            end else begin
               w_nxt_sub = r_sub + 1'b1;
            end
         end
         S_TRIGGER: begin
            if (r_wait == c_trig_last) begin
               w_nxt_wait  = '0;
               w_nxt_state = S_SETTLE;
            end else begin
               w_nxt_wait = r_wait + 1'b1;
            end
         end
         S_SETTLE: begin
            if (r_wait == c_settle_last) begin
               w_nxt_wait  = '0;
               w_nxt_sub   = '0;
               w_nxt_bit   = '0;
               w_nxt_state = S_SHIFT_OUT;
            end else begin
               w_nxt_wait = r_wait + 1'b1;
            end
         end
         S_DONE:  w_nxt_state = S_IDLE;
         default: w_nxt_state = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered pins line up with r_state
   always_comb begin
      w_nxt_chal_a = w_accept ? challenge_a : r_chal_a;
      w_nxt_chal_b = w_accept ? challenge_b : r_chal_b;
      w_shifting   = (w_nxt_state == S_SHIFT_IN) || (w_nxt_state == S_SHIFT_OUT);
      w_nxt_ph1    = w_shifting && (w_nxt_sub >= c_s1_lo) && (w_nxt_sub < c_s2_lo);
      w_nxt_ph2    = w_shifting && (w_nxt_sub >= c_s3_lo);
      w_nxt_ca     = (w_nxt_state == S_SHIFT_IN) && w_nxt_chal_a[w_nxt_bit];
      w_nxt_cb     = (w_nxt_state == S_SHIFT_IN) && w_nxt_chal_b[w_nxt_bit];
      w_nxt_busy   = (w_nxt_state == S_SHIFT_IN) || (w_nxt_state == S_TRIGGER) ||
                     (w_nxt_state == S_SETTLE)   || (w_nxt_state == S_SHIFT_OUT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_sub         <= '0;
         r_bit         <= '0;
         r_wait        <= '0;
         r_chal_a      <= '0;
         r_chal_b      <= '0;
         ph1           <= 1'b0;
         ph2           <= 1'b0;
         ca_si         <= 1'b0;
         cb_si         <= 1'b0;
         ph_en         <= 1'b0;
         out_en        <= 1'b0;
         trig          <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         response_up   <= '0;
         response_down <= '0;
      end else begin
         r_state  <= w_nxt_state;
         r_sub    <= w_nxt_sub;
         r_bit    <= w_nxt_bit;
         r_wait   <= w_nxt_wait;
         r_chal_a <= w_nxt_chal_a;
         r_chal_b <= w_nxt_chal_b;
         ph1      <= w_nxt_ph1;
         ph2      <= w_nxt_ph2;
         ca_si    <= w_nxt_ca;
         cb_si    <= w_nxt_cb;
         ph_en    <= (w_nxt_state == S_SHIFT_IN);
         out_en   <= (w_nxt_state == S_SHIFT_OUT);
         trig     <= (w_nxt_state == S_TRIGGER);
         busy     <= w_nxt_busy;
         done     <= (w_nxt_state == S_DONE);
         if (w_accept) begin
            response_up   <= '0;
            response_down <= '0;
         end else if (w_sample) begin
            response_up[r_bit]   <= so_up;
            response_down[r_bit] <= so_down;
         end
      end
   end

`ifdef PUF_COMPL_CHECK_EN
   logic w_compl_bad;
   assign w_compl_bad = (so_not_up == so_up) || (so_not_down == so_down);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_err <= 1'b0;
      end else if (w_accept) begin
         resp_err <= 1'b0;
      end else if (w_sample && w_compl_bad) begin
         resp_err <= 1'b1;
      end
   end
`else
   logic w_unused_compl;
   assign w_unused_compl = so_not_up ^ so_not_down;
   assign resp_err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_puf_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_puf_sequencer                                              |
// | Purpose  : Scoreboard bench for puf_sequencer with a behavioural PUF     |
// |            (up = A|B, down = A&B) and a phase-clock monitor.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_puf_sequencer;

   localparam int CB      = 128;
   localparam int LATENCY = 2061;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [CB-1:0] challenge_a, challenge_b;
   logic          busy, done, resp_err;
   logic [CB-1:0] response_up, response_down;
   logic          ph1, ph2, ca_si, cb_si, ph_en, out_en, trig;
   logic          so_up, so_not_up, so_down, so_not_down;

   puf_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .challenge_a(challenge_a), .challenge_b(challenge_b),
      .busy(busy), .done(done),
      .response_up(response_up), .response_down(response_down), .resp_err(resp_err),
      .ph1(ph1), .ph2(ph2), .ca_si(ca_si), .cb_si(cb_si),
      .ph_en(ph_en), .out_en(out_en), .trig(trig),
      .so_up(so_up), .so_not_up(so_not_up), .so_down(so_down), .so_not_down(so_not_down)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural PUF and phase-clock monitor
   logic [CB-1:0] chain_a = '0, chain_b = '0, up_sh = '0, dn_sh = '0;
   int  out_idx = 0;
   bit  inj = 1'b0;
   logic prev_ph1 = 1'b0, prev_trig = 1'b0, prev_ph_en = 1'b0;
   int  n_ph1_in = 0, n_ph1_out = 0, n_trig = 0, n_overlap = 0;
   logic ca_first = 1'b0, cb_first = 1'b0;

   assign so_up       = up_sh[0];
   assign so_down     = dn_sh[0];
   assign so_not_up   = (inj && out_idx == 37) ? up_sh[0] : ~up_sh[0];
   assign so_not_down = ~dn_sh[0];

   always @(negedge clk) begin
      if (!rst_n) begin
         chain_a <= '0; chain_b <= '0; up_sh <= '0; dn_sh <= '0;
         out_idx <= 0; prev_ph1 <= 1'b0; prev_trig <= 1'b0; prev_ph_en <= 1'b0;
      end else begin
         if (ph1 && !prev_ph1) begin
            if (ph_en) begin
               chain_a  <= {ca_si, chain_a[CB-1:1]};
               chain_b  <= {cb_si, chain_b[CB-1:1]};
               n_ph1_in <= n_ph1_in + 1;
            end
            if (out_en) begin
               up_sh     <= up_sh >> 1;
               dn_sh     <= dn_sh >> 1;
               out_idx   <= out_idx + 1;
               n_ph1_out <= n_ph1_out + 1;
            end
         end
         if (trig && !prev_trig) begin
            up_sh   <= chain_a | chain_b;
            dn_sh   <= chain_a & chain_b;
            out_idx <= 0;
         end
         if (trig)       n_trig    <= n_trig + 1;
         if (ph1 && ph2) n_overlap <= n_overlap + 1;
         if (ph_en && !prev_ph_en) begin
            ca_first <= ca_si;
            cb_first <= cb_si;
         end
         prev_ph1   <= ph1;
         prev_trig  <= trig;
         prev_ph_en <= ph_en;
      end
   end

   // Scoreboard
   typedef struct {
      logic [CB-1:0] up;
      logic [CB-1:0] dn;
      logic          err;
      int            start_cyc;
   } exp_t;
   exp_t sb_q[$];
   exp_t mon_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
      end else if (done) begin
         if (sb_q.size() == 0) begin
            chk("spurious_done_queue_depth", 256'(sb_q.size()), 256'd1);
         end else begin
            mon_e = sb_q.pop_front();
            chk("response_up",   256'(response_up),   256'(mon_e.up));
            chk("response_down", 256'(response_down), 256'(mon_e.dn));
            chk("resp_err",      256'(resp_err),      256'(mon_e.err));
            chk("done_latency",  256'(cyc - mon_e.start_cyc + 1), 256'(LATENCY));
            chk("busy_at_done",  256'(busy), 256'd0);
         end
      end
   end

   logic [11:0] ctl;
   assign ctl = {ph1, ph2, ph_en, out_en, trig, ca_si, cb_si, busy, done, resp_err,
                 |response_up, |response_down};

   task automatic run_case(input logic [CB-1:0] a, input logic [CB-1:0] b,
                           input logic [CB-1:0] exp_up, input logic [CB-1:0] exp_dn,
                           input bit inject, input int repulse_at, input int reset_at);
      int  s_in, s_out, s_trig;
      bit  got;
      logic e_err;
`ifdef PUF_COMPL_CHECK_EN
      e_err = inject;
`else
      e_err = 1'b0;
`endif
      @(negedge clk);
      challenge_a = a; challenge_b = b; inj = inject; start = 1'b1;
      s_in = n_ph1_in; s_out = n_ph1_out; s_trig = n_trig;
      @(negedge clk);
      start = 1'b0;
      sb_q.push_back('{exp_up, exp_dn, e_err, cyc});
      chk("busy_after_start", 256'(busy), 256'd1);
      chk("responses_cleared_on_start", {response_up, response_down}, 256'd0);
      chk("resp_err_cleared_on_start", 256'(resp_err), 256'd0);
      got = 1'b0;
      for (int i = 2; i <= 3000 && !got; i++) begin
         start = (i == repulse_at);
         if (i == repulse_at) challenge_a = ~a;
         if (i == reset_at) begin
            rst_n = 1'b0;
            #1;
            chk("abort_outputs_zero", 256'(ctl), 256'd0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (2200) @(negedge clk);
            chk("abort_no_busy", 256'(busy), 256'd0);
            return;
         end
         @(negedge clk);
         if (done) got = 1'b1;
      end
      start = 1'b0;
      chk("done_seen", 256'(got), 256'd1);
      chk("ph1_pulses_ph_en",  256'(n_ph1_in - s_in),   256'd128);
      chk("ph1_pulses_out_en", 256'(n_ph1_out - s_out), 256'd128);
      chk("trig_cycles",       256'(n_trig - s_trig),   256'd4);
      chk("ca_si_slot0", 256'(ca_first), 256'(a[0]));
      chk("cb_si_slot0", 256'(cb_first), 256'(b[0]));
      repeat (3) @(negedge clk);
      chk("resp_err_holds", 256'(resp_err), 256'(e_err));
      chk("response_up_holds", 256'(response_up), 256'(exp_up));
   endtask

   initial begin
      logic [11:0] idle_acc;
      rst_n = 1'b0; start = 1'b0; challenge_a = '0; challenge_b = '0;
      repeat (4) @(negedge clk);
      chk("reset_outputs", 256'(ctl), 256'd0);
      rst_n = 1'b1;
      idle_acc = '0;
      repeat (50) begin
         @(negedge clk);
         idle_acc = idle_acc | ctl;
      end
      chk("idle_outputs_stay_low", 256'(idle_acc), 256'd0);

      run_case({CB{1'b1}}, '0, {CB{1'b1}}, '0, 1'b0, 0, 0);
      run_case(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
               128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000,
               128'hFFFF_4567_FFFF_CDEF_FFFF_BA98_FFFF_3210,
               128'h0123_0000_89AB_0000_FEDC_0000_7654_0000, 1'b0, 0, 0);
      run_case({32{4'hA}}, {32{4'h5}} ^ {16{8'h5A}},
               {32{4'hA}} | ({32{4'h5}} ^ {16{8'h5A}}),
               {32{4'hA}} & ({32{4'h5}} ^ {16{8'h5A}}), 1'b1, 500, 0);
      run_case(128'h1, 128'h8000_0000_0000_0000_0000_0000_0000_0000,
               128'h8000_0000_0000_0000_0000_0000_0000_0001, '0, 1'b0, 0, 0);
      run_case({CB{1'b1}}, {CB{1'b1}}, {CB{1'b1}}, {CB{1'b1}}, 1'b0, 0, 1500);
      run_case(128'hC3C3_0000_0000_0000_0000_0000_0000_00F0,
               128'h0000_0000_0000_0000_0000_0000_0000_0F0F,
               128'hC3C3_0000_0000_0000_0000_0000_0000_0FFF,
               128'h0000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 0, 0);

      chk("ph1_ph2_overlap", 256'(n_overlap), 256'd0);
      chk("scoreboard_drained", 256'(sb_q.size()), 256'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
